fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Pipelined Y86-64 fetch stage.
- Drives the instruction memory address and takes back the raw bytes, byte0 and byte19, plus imem_err.
- Splits the bytes into instruction fields, computes valP and the predicted next PC, and selects the fetch PC from the redirect inputs.
- Registers the result into the F→D pipeline register consumed by decode.
- Holds the PC after a halt or faulting fetch until a redirect arrives.

Parameters:
RESET_PC, 64'd0, PC loaded into F_predPC on reset.
IMEM_BYTES, 1025, instruction memory size; informational only, imem_err is authoritative.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
pc  out  64  fetch address to instruction memory (combinational f_pc)
byte0  in  8  byte at pc: icode[7:4], ifun[3:0]
byte19  in  72  bytes pc+1..pc+9; [71:64]=byte1, [63:56]=byte2 … [7:0]=byte9
imem_err  in  1  address fault for current pc
stall_f  in  1  hold F_predPC and FSM state
stall_d  in  1  hold the D register
bubble_d  in  1  load a bubble into the D register
mis_valid  in  1  mispredicted jXX redirect
mis_pc  in  64  fall-through target for mis_valid
ret_valid  in  1  ret redirect
ret_pc  in  64  return address for ret_valid
D_stat  out  3  status: AOK=1, HLT=2, ADR=3, INS=4
D_icode  out  4  decoded icode
D_ifun  out  4  decoded ifun
D_rA  out  4  register A (4'hF when absent)
D_rB  out  4  register B (4'hF when absent)
D_valC  out  64  constant word
D_valP  out  64  incremented PC
D_valid  out  1  1 = real instruction, 0 = bubble

Behaviour:
PC select (combinational):
- f_pc = mis_valid ? mis_pc : ret_valid ? ret_pc : F_predPC. mis_valid has priority.
- pc = f_pc.

Field split:
- icode = byte0[7:4], ifun = byte0[3:0].
- need_regids for icode in {2,3,4,5,6,A,B}.
- need_valC for icode in {3,4,5,7,8}.
- When need_regids: rA = byte1[7:4], rB = byte1[3:0], valC = little-endian byte2..byte9 (byte2 is the LSB).
- Otherwise: rA = rB = F, valC = little-endian byte1..byte8 (byte1 is the LSB).
- valP = f_pc + 1 + need_regids + 8*need_valC, 64-bit wrap.

Instruction validity:
- icode ≤ B is required.
- ifun ≤ 6 for icode 2 and 7; ifun ≤ 3 for icode 6; ifun == 0 for all other icodes.

Status and predicted PC:
- f_stat: imem_err → ADR (icode and ifun forced to 1/0); else invalid → INS; else icode 0 → HLT; else AOK.
- f_predPC = valC for icode 7 and 8; valP otherwise.

FSM, states RUN and HOLD:
- RUN: if !stall_f, F_predPC <= f_predPC. If f_stat != AOK and no redirect, go to HOLD with F_predPC <= f_pc, so the PC freezes on the faulting address.
- HOLD: F_predPC is not updated, and the D register loads bubbles when not stalled. A redirect (mis_valid or ret_valid) forces RUN and fetches normally in that same cycle.
- stall_f freezes both the state and F_predPC, but a redirect still drives pc combinationally.

D register update (rising clk):
- Priority: stall_d (hold) > bubble_d (bubble) > HOLD without redirect (bubble) > fetched fields.
- Fetched fields load with D_valid = 1 and D_stat = f_stat.
- Bubble = stat AOK, icode 1, ifun 0, rA = rB = F, valC = 0, valP = 0, valid 0.

Reset (async, rst high):
- F_predPC = RESET_PC, state RUN, D register = bubble.
- Asserting rst mid-operation discards any HOLD state and in-flight D contents immediately.
- Latency: one cycle from pc to D outputs.

Decomposition:
Shared package y86_pkg holds:
- icode constants (I_HALT..I_POPQ)
- stat encodings (S_AOK, S_HLT, S_ADR, S_INS)
- RNONE = 4'hF
- the bubble constant
Natural sub-module: fetch_split, combinational; maps byte0/byte19/f_pc/imem_err to icode, ifun, rA, rB, valC, valP, f_stat, f_predPC. The top keeps PC select, FSM and the D register.

Test Plan:
1. Reset, RESET_PC = 0; memory holds 30 F4 0E 00…00 → after 1 clk: D_icode 3, D_rB 4, D_valC 14, D_valP 10, D_stat 1, pc = 10.
2. At pc 26, bytes 75 26 00…00 (jle) → D_valC 38, D_valP 35, next pc 38. Then assert mis_valid with mis_pc 35 → pc = 35 the same cycle, and F_predPC follows the instruction fetched at 35.
3. Fetch 00 at pc 40 → D_stat 2; state HOLD; pc stays 40; following cycles D_valid 0. Then ret_valid with ret_pc 12 → RUN, pc = 12.
4. byte0 = C0 → D_stat 4 and HOLD. byte0 = 68 (opq with ifun 8) → INS. imem_err = 1 → D_stat 3, D_icode 1.
5. stall_f and stall_d held high for 3 clk → pc and all D_* unchanged. bubble_d alone → D_icode 1, D_valid 0. stall_d with bubble_d → D held.
6. Assert rst asynchronously between clock edges while in HOLD → D bubble and pc = RESET_PC immediately, state RUN.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the fetch stage.
//   - icode constants I_HALT..I_POPQ
//   - status encodings S_AOK/S_HLT/S_ADR/S_INS
//   - RNONE (no-register marker)
//   - the F->D pipeline register layout and its bubble value
//   - the fetch FSM state type
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    localparam logic [3:0] RNONE = 4'hF;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
        logic        valid;
    } d_reg_t;

    localparam d_reg_t D_BUBBLE = '{
        stat:  S_AOK,
        icode: I_NOP,
        ifun:  4'h0,
        ra:    RNONE,
        rb:    RNONE,
        valc:  64'd0,
        valp:  64'd0,
        valid: 1'b0
    };

    typedef enum logic {
        F_RUN  = 1'b0,
        F_HOLD = 1'b1
    } fstate_t;

endpackage

// File: rtl/fetch_split.sv
// Combinational instruction splitter for the Y86-64 fetch stage.
// Ports:
//   f_pc      in  64  address the bytes were fetched from
//   byte0     in   8  icode/ifun byte
//   byte19    in  72  bytes pc+1..pc+9, byte1 in [71:64]
//   imem_err  in   1  address fault for f_pc
//   icode/ifun/ra/rb/valc/valp  out  decoded fields
//   stat      out  3  fetch status
//   pred_pc   out 64  predicted next PC
module fetch_split
    import y86_pkg::*;
(
    input  logic [63:0] f_pc,
    input  logic [7:0]  byte0,
    input  logic [71:0] byte19,
    input  logic        imem_err,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  ra,
    output logic [3:0]  rb,
    output logic [63:0] valc,
    output logic [63:0] valp,
    output logic [2:0]  stat,
    output logic [63:0] pred_pc
);

    // Memory delivers the first byte in the top lane; the constant word is
    // little-endian, so the lanes are reversed to form the value.
    function automatic logic [63:0] byte_swap(input logic [63:0] v);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i*8 +: 8] = v[(7-i)*8 +: 8];
        end
        return r;
    endfunction

    function automatic logic instr_ok(input logic [3:0] ic, input logic [3:0] fn);
        logic ok;
        if (ic > I_POPQ) begin
            ok = 1'b0;
        end else begin
            case (ic)
                I_RRMOVQ, I_JXX: ok = (fn <= 4'd6);
                I_OPQ:           ok = (fn <= 4'd3);
                default:         ok = (fn == 4'd0);
            endcase
        end
        return ok;
    endfunction

    logic need_regids;
    logic need_valc;
    logic valid_instr;

    always_comb begin
        icode = byte0[7:4];
        ifun  = byte0[3:0];
        // A faulting fetch is reported as a nop-shaped instruction so that
        // downstream stages see harmless fields alongside the ADR status.
        if (imem_err) begin
            icode = I_NOP;
            ifun  = 4'h0;
        end

        need_regids = (icode == I_RRMOVQ) || (icode == I_IRMOVQ) ||
                      (icode == I_RMMOVQ) || (icode == I_MRMOVQ) ||
                      (icode == I_OPQ)    || (icode == I_PUSHQ)  ||
                      (icode == I_POPQ);
        need_valc   = (icode == I_IRMOVQ) || (icode == I_RMMOVQ) ||
                      (icode == I_MRMOVQ) || (icode == I_JXX)    ||
                      (icode == I_CALL);

        if (need_regids) begin
            ra   = byte19[71:68];
            rb   = byte19[67:64];
            valc = byte_swap(byte19[63:0]);
        end else begin
            ra   = RNONE;
            rb   = RNONE;
            valc = byte_swap(byte19[71:8]);
        end

        valp = f_pc + 64'd1 + {63'd0, need_regids} + (need_valc ? 64'd8 : 64'd0);

        valid_instr = instr_ok(icode, ifun);
        if (imem_err) begin
            stat = S_ADR;
        end else if (!valid_instr) begin
            stat = S_INS;
        end else if (icode == I_HALT) begin
            stat = S_HLT;
        end else begin
            stat = S_AOK;
        end

        pred_pc = ((icode == I_JXX) || (icode == I_CALL)) ? valc : valp;
    end

endmodule

// File: rtl/fetch_stage.sv
// Pipelined Y86-64 fetch stage: PC select, RUN/HOLD control and the F->D
// pipeline register.
// Ports:
//   clk, rst                 clock (rising) and async active-high reset
//   pc                 out   fetch address (combinational)
//   byte0, byte19, imem_err  instruction bytes and fault for pc
//   stall_f, stall_d, bubble_d   pipeline control
//   mis_valid/mis_pc, ret_valid/ret_pc   redirect requests
//   D_stat..D_valid    out   F->D register contents
module fetch_stage
    import y86_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = 64'd0,
    parameter int          IMEM_BYTES = 1025
) (
    input  logic        clk,
    input  logic        rst,
    output logic [63:0] pc,
    input  logic [7:0]  byte0,
    input  logic [71:0] byte19,
    input  logic        imem_err,
    input  logic        stall_f,
    input  logic        stall_d,
    input  logic        bubble_d,
    input  logic        mis_valid,
    input  logic [63:0] mis_pc,
    input  logic        ret_valid,
    input  logic [63:0] ret_pc,
    output logic [2:0]  D_stat,
    output logic [3:0]  D_icode,
    output logic [3:0]  D_ifun,
    output logic [3:0]  D_rA,
    output logic [3:0]  D_rB,
    output logic [63:0] D_valC,
    output logic [63:0] D_valP,
    output logic        D_valid
);

    logic [63:0] pred_pc_p0;
    fstate_t     state_p0;
    d_reg_t      d_p1;

    logic [63:0] f_pc;
    logic        redirect;
    logic [3:0]  f_icode;
    logic [3:0]  f_ifun;
    logic [3:0]  f_ra;
    logic [3:0]  f_rb;
    logic [63:0] f_valc;
    logic [63:0] f_valp;
    logic [2:0]  f_stat;
    logic [63:0] f_pred_pc;

    // ---- stage F: PC select and field split ----
    assign redirect = mis_valid || ret_valid;
    assign f_pc     = mis_valid ? mis_pc : (ret_valid ? ret_pc : pred_pc_p0);
    assign pc       = f_pc;

    fetch_split u_split (
        .f_pc     (f_pc),
        .byte0    (byte0),
        .byte19   (byte19),
        .imem_err (imem_err),
        .icode    (f_icode),
        .ifun     (f_ifun),
        .ra       (f_ra),
        .rb       (f_rb),
        .valc     (f_valc),
        .valp     (f_valp),
        .stat     (f_stat),
        .pred_pc  (f_pred_pc)
    );

    // A redirect in HOLD resumes fetching in the same cycle, so the update
    // rule is identical to RUN whenever a redirect is present.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_p0   <= F_RUN;
            pred_pc_p0 <= RESET_PC;
        end else if (!stall_f) begin
            if (state_p0 == F_RUN || redirect) begin
                if (f_stat != S_AOK && !redirect) begin
                    state_p0   <= F_HOLD;
                    pred_pc_p0 <= f_pc;
                end else begin
                    state_p0   <= F_RUN;
                    pred_pc_p0 <= f_pred_pc;
                end
            end
        end
    end

    // ---- stage F -> D register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_p1 <= D_BUBBLE;
        end else if (stall_d) begin
            d_p1 <= d_p1;
        end else if (bubble_d || (state_p0 == F_HOLD && !redirect)) begin
            d_p1 <= D_BUBBLE;
        end else begin
            d_p1 <= '{
                stat:  f_stat,
                icode: f_icode,
                ifun:  f_ifun,
                ra:    f_ra,
                rb:    f_rb,
                valc:  f_valc,
                valp:  f_valp,
                valid: 1'b1
            };
        end
    end

    assign D_stat  = d_p1.stat;
    assign D_icode = d_p1.icode;
    assign D_ifun  = d_p1.ifun;
    assign D_rA    = d_p1.ra;
    assign D_rB    = d_p1.rb;
    assign D_valC  = d_p1.valc;
    assign D_valP  = d_p1.valp;
    assign D_valid = d_p1.valid;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] pc;
    logic [7:0]  byte0;
    logic [71:0] byte19;
    logic        imem_err;
    logic        stall_f, stall_d, bubble_d;
    logic        mis_valid, ret_valid;
    logic [63:0] mis_pc, ret_pc;
    logic [2:0]  D_stat;
    logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
    logic [63:0] D_valC, D_valP;
    logic        D_valid;

    logic [7:0] mem [256];

    int checks = 0;
    int errors = 0;

    fetch_stage #(.RESET_PC(64'd0), .IMEM_BYTES(1025)) dut (
        .clk       (clk),
        .rst       (rst),
        .pc        (pc),
        .byte0     (byte0),
        .byte19    (byte19),
        .imem_err  (imem_err),
        .stall_f   (stall_f),
        .stall_d   (stall_d),
        .bubble_d  (bubble_d),
        .mis_valid (mis_valid),
        .mis_pc    (mis_pc),
        .ret_valid (ret_valid),
        .ret_pc    (ret_pc),
        .D_stat    (D_stat),
        .D_icode   (D_icode),
        .D_ifun    (D_ifun),
        .D_rA      (D_rA),
        .D_rB      (D_rB),
        .D_valC    (D_valC),
        .D_valP    (D_valP),
        .D_valid   (D_valid)
    );

    always #5 clk = ~clk;

    // Instruction memory model (256-byte wrap)
    always_comb begin
        logic [7:0] base;
        base   = pc[7:0];
        byte0  = mem[base];
        byte19 = '0;
        for (int i = 1; i <= 9; i++) begin
            byte19[(9-i)*8 +: 8] = mem[8'(base + 8'(i))];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; imem_err = 1'b0;
        stall_f = 1'b0; stall_d = 1'b0; bubble_d = 1'b0;
        mis_valid = 1'b0; ret_valid = 1'b0; mis_pc = '0; ret_pc = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        // 0: irmovq $14,%rsp
        mem[0] = 8'h30; mem[1] = 8'hF4; mem[2] = 8'h0E;
        mem[10] = 8'h10; mem[11] = 8'h10;           // nop, nop
        mem[12] = 8'h60; mem[13] = 8'h01;           // addq %rax,%rcx
        mem[14] = 8'hC0;                            // invalid icode
        mem[16] = 8'h68;                            // opq ifun 8
        mem[26] = 8'h75; mem[27] = 8'h26;           // jle 0x26
        for (int i = 35; i < 40; i++) mem[i] = 8'h10;
        mem[40] = 8'h00;                            // halt

        #12;
        check("rst_pc", pc, 64'd0);
        check("rst_valid", D_valid, 1'b0);
        check("rst_icode", D_icode, 4'h1);
        check("rst_stat", D_stat, 3'd1);
        check("rst_ra", D_rA, 4'hF);
        rst = 1'b0;

        // irmovq
        tick();
        check("irm_icode", D_icode, 4'h3);
        check("irm_ra", D_rA, 4'hF);
        check("irm_rb", D_rB, 4'h4);
        check("irm_valc", D_valC, 64'd14);
        check("irm_valp", D_valP, 64'd10);
        check("irm_stat", D_stat, 3'd1);
        check("irm_valid", D_valid, 1'b1);
        check("irm_pc", pc, 64'd10);

        // jle at 26 via redirect
        mis_valid = 1'b1; mis_pc = 64'd26; #1;
        check("mis26_pc", pc, 64'd26);
        tick(); mis_valid = 1'b0; #1;
        check("jle_icode", D_icode, 4'h7);
        check("jle_ifun", D_ifun, 4'h5);
        check("jle_valc", D_valC, 64'd38);
        check("jle_valp", D_valP, 64'd35);
        check("jle_pred", pc, 64'd38);
        mis_valid = 1'b1; mis_pc = 64'd35; #1;
        check("mis35_pc", pc, 64'd35);
        tick(); mis_valid = 1'b0; #1;
        check("nop35_valp", D_valP, 64'd36);
        check("nop35_pc", pc, 64'd36);

        // run to halt at 40
        repeat (4) tick();
        check("pre_halt_pc", pc, 64'd40);
        tick();
        check("halt_stat", D_stat, 3'd2);
        check("halt_icode", D_icode, 4'h0);
        check("halt_pc", pc, 64'd40);
        tick();
        check("hold_valid", D_valid, 1'b0);
        check("hold_icode", D_icode, 4'h1);
        check("hold_pc", pc, 64'd40);
        ret_valid = 1'b1; ret_pc = 64'd12; #1;
        check("ret_pc", pc, 64'd12);
        tick(); ret_valid = 1'b0; #1;
        check("addq_icode", D_icode, 4'h6);
        check("addq_ra", D_rA, 4'h0);
        check("addq_rb", D_rB, 4'h1);
        check("addq_valp", D_valP, 64'd14);
        check("addq_valid", D_valid, 1'b1);
        check("addq_pc", pc, 64'd14);

        // invalid instructions and address fault
        tick();
        check("c0_stat", D_stat, 3'd4);
        check("c0_icode", D_icode, 4'hC);
        check("c0_pc", pc, 64'd14);
        mis_valid = 1'b1; mis_pc = 64'd16;
        tick(); mis_valid = 1'b0; #1;
        check("op8_stat", D_stat, 3'd4);
        check("op8_ifun", D_ifun, 4'h8);
        check("op8_pc", pc, 64'd18);
        imem_err = 1'b1;
        tick(); imem_err = 1'b0; #1;
        check("adr_stat", D_stat, 3'd3);
        check("adr_icode", D_icode, 4'h1);
        check("adr_ifun", D_ifun, 4'h0);
        check("adr_pc", pc, 64'd18);
        tick();
        check("adr_hold_valid", D_valid, 1'b0);
        check("adr_hold_pc", pc, 64'd18);

        // stalls and bubbles
        ret_valid = 1'b1; ret_pc = 64'd0;
        tick(); ret_valid = 1'b0; #1;
        check("rerun_icode", D_icode, 4'h3);
        check("rerun_pc", pc, 64'd10);
        stall_f = 1'b1; stall_d = 1'b1;
        repeat (3) tick();
        check("stall_pc", pc, 64'd10);
        check("stall_icode", D_icode, 4'h3);
        check("stall_valc", D_valC, 64'd14);
        check("stall_valp", D_valP, 64'd10);
        check("stall_valid", D_valid, 1'b1);
        stall_f = 1'b0; stall_d = 1'b0;
        tick();
        check("nop10_icode", D_icode, 4'h1);
        check("nop10_valp", D_valP, 64'd11);
        check("nop10_pc", pc, 64'd11);
        stall_d = 1'b1; bubble_d = 1'b1;
        tick(); stall_d = 1'b0; bubble_d = 1'b0; #1;
        check("sd_bd_valp", D_valP, 64'd11);
        check("sd_bd_valid", D_valid, 1'b1);
        check("sd_bd_pc", pc, 64'd12);
        bubble_d = 1'b1;
        tick(); bubble_d = 1'b0; #1;
        check("bd_valid", D_valid, 1'b0);
        check("bd_icode", D_icode, 4'h1);
        check("bd_valp", D_valP, 64'd0);
        check("bd_pc", pc, 64'd14);

        // async reset while in HOLD
        tick();
        check("hold2_stat", D_stat, 3'd4);
        check("hold2_pc", pc, 64'd14);
        #2 rst = 1'b1; #1;
        check("arst_pc", pc, 64'd0);
        check("arst_valid", D_valid, 1'b0);
        check("arst_icode", D_icode, 4'h1);
        check("arst_stat", D_stat, 3'd1);
        #1 rst = 1'b0;
        tick();
        check("post_rst_icode", D_icode, 4'h3);
        check("post_rst_pc", pc, 64'd10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
